// File: rtl/timer_pkg.sv
// Shared types and default sizes for the timer sequencer and its counter.
package timer_pkg;

  localparam int unsigned DefWidth = 3;
  localparam int unsigned DefRepW  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } tmr_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after reaching a programmable terminal value.
module wrap_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  logic [WIDTH-1:0] count_q;

  assign count    = count_q;
  assign at_limit = (count_q == limit);

  // Count state: clear wins over enable; wrap on the cycle the limit is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= at_limit ? '0 : count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencer that accepts a period/repetition config, then runs, stops and
// completes a wrap counter, flagging each wrap and the end of the program.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned REP_W = DefRepW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  tmr_state_e       state_q;
  logic [WIDTH-1:0] limit_q;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_inc;
  logic             at_limit;
  logic             cnt_en;
  logic             cnt_clr;
  logic             last_rep;

  // The counter only moves in RUN and sits at zero in every other state, so
  // entering RUN always starts from zero and a stop returns it to zero.
  assign cnt_en  = (state_q == RUN);
  assign cnt_clr = (state_q != RUN) || stop;

  assign rep_inc  = rep_q + REP_W'(1);
  assign last_rep = (reps_q != '0) && (rep_inc == reps_q);

  wrap_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .limit    (limit_q),
    .count    (count),
    .at_limit (at_limit)
  );

  // Outputs decoded straight from the registered state.
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign tick      = (state_q == RUN) && at_limit;

  // Control FSM with config and repetition registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      limit_q <= '0;
      reps_q  <= '0;
      rep_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            limit_q <= cfg_limit;
            reps_q  <= cfg_reps;
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (start) begin
            rep_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (at_limit && (reps_q != '0)) begin
            // Free-running mode leaves the rep counter alone so it never wraps.
            if (last_rep) begin
              rep_q   <= '0;
              state_q <= DONE;
            end else begin
              rep_q <= rep_inc;
            end
          end
        end
        DONE: begin
          state_q <= ARMED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
